// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the binary-to-Gray encoder and the
// Gray-to-binary decoder.
package gray_pkg;

  // Widest word either codec supports.
  localparam int unsigned GRAY_W_MAX = 32;

  // Reflected Gray code of the low 'width' bits of b. Bits at and above
  // 'width' are cleared so the caller can slice out its own word.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(
    input logic [GRAY_W_MAX-1:0] b,
    input int unsigned           width
  );
    logic [GRAY_W_MAX-1:0] mask;
    if (width >= GRAY_W_MAX) begin
      mask = '1;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    // Logical shift: the MSB passes through unchanged, no sign extension.
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Number of set bits in a full-width word (0..GRAY_W_MAX).
  function automatic logic [5:0] gray_popcount(
    input logic [GRAY_W_MAX-1:0] x
  );
    logic [GRAY_W_MAX-1:0] v;
    logic [5:0]            c;
    v = x;
    c = '0;
    for (int unsigned i = 0; i < GRAY_W_MAX; i++) begin
      c = c + {5'd0, v[0]};
      v = v >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_adj_chk.sv
// Combinational Gray adjacency check: high when the two codes differ in
// exactly one bit. Identical codes are not adjacent.
module gray_adj_chk
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] new_gray_i,
  input  logic [WIDTH-1:0] prev_gray_i,
  output logic             adj_o
);

  logic [GRAY_W_MAX-1:0] diff;

  // Zero-extend the difference and test for a single set bit.
  always_comb begin
    diff                = '0;
    diff[WIDTH-1:0]     = new_gray_i ^ prev_gray_i;
    adj_o               = (gray_popcount(diff) == 6'd1);
  end

endmodule

// File: rtl/bin_to_gray_enc.sv
// Streaming binary-to-Gray encoder. Two-stage elastic pipeline with a
// valid/ready handshake on each side: S1 holds the raw binary word, S2 holds
// the encoded word plus the adjacency flag and drives the outputs from flops.
module bin_to_gray_enc
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_adj
);

  // Stage 1: raw binary word.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_bin_q,   s1_bin_d;

  // Stage 2: encoded word and adjacency flag.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_gray_q,  s2_gray_d;
  logic             s2_adj_q,   s2_adj_d;

  // Adjacency history: last code loaded into S2.
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             prev_seen_q, prev_seen_d;

  // Handshake and datapath nets.
  logic             s2_load;
  logic             in_fire;
  logic [GRAY_W_MAX-1:0] bin_ext;
  logic [GRAY_W_MAX-1:0] gray_ext;
  logic [WIDTH-1:0] enc_gray;
  logic             adj_raw;
  logic             unused_gray_hi;

  // S2 takes S1's word when S2 is empty or its word leaves this cycle.
  // in_ready follows s2_load combinationally so a full pipe re-opens in the
  // same cycle out_ready rises (no bubble).
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_fire  = in_valid & in_ready;

  // Encode the S1 word through the shared package function.
  always_comb begin
    bin_ext             = '0;
    bin_ext[WIDTH-1:0]  = s1_bin_q;
    gray_ext            = bin2gray(bin_ext, WIDTH);
    enc_gray            = gray_ext[WIDTH-1:0];
    // Bits above WIDTH are zero by construction.
    unused_gray_hi      = ^gray_ext;
  end

  gray_adj_chk #(
    .WIDTH (WIDTH)
  ) u_adj_chk (
    .new_gray_i  (enc_gray),
    .prev_gray_i (prev_gray_q),
    .adj_o       (adj_raw)
  );

  // S1 next state: load on input transfer, otherwise empty when drained.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_bin_d   = s1_bin_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_bin_d   = in_bin;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 and history next state: load from S1, otherwise empty on output
  // transfer; contents are held while stalled.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_gray_d   = s2_gray_q;
    s2_adj_d    = s2_adj_q;
    prev_gray_d = prev_gray_q;
    prev_seen_d = prev_seen_q;
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_gray_d   = enc_gray;
      s2_adj_d    = prev_seen_q & adj_raw;
      prev_gray_d = enc_gray;
      prev_seen_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end
  end

  // Pipeline and history registers; reset discards in-flight words and
  // clears adjacency history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_bin_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_gray_q   <= '0;
      s2_adj_q    <= 1'b0;
      prev_gray_q <= '0;
      prev_seen_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_bin_q    <= s1_bin_d;
      s2_valid_q  <= s2_valid_d;
      s2_gray_q   <= s2_gray_d;
      s2_adj_q    <= s2_adj_d;
      prev_gray_q <= prev_gray_d;
      prev_seen_q <= prev_seen_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_gray  = s2_gray_q;
  assign out_adj   = s2_adj_q;

endmodule

// File: tb/tb_bin_to_gray_enc.sv
// Directed and random-stall bench for bin_to_gray_enc (WIDTH = 4).
module tb_bin_to_gray_enc;

  localparam int unsigned W = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_bin    = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gray;
  logic         out_adj;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] g;
    logic         a;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_prev    = '0;
  logic         m_seen    = 1'b0;
  bit           auto_push = 1'b0;
  bit           hold_pend = 1'b0;
  logic [W-1:0] hold_g    = '0;
  logic         hold_a    = 1'b0;
  int           n_out     = 0;
  bit           last_acc  = 1'b0;

  bin_to_gray_enc #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_adj   (out_adj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push_exp(input logic [W-1:0] gv, input logic av);
    exp_q.push_back('{g: gv, a: av});
    m_prev = gv;
    m_seen = 1'b1;
  endtask

  // One clock: drive, check pre-edge handshake, advance past the edge.
  task automatic run_cycle(input logic v, input logic [W-1:0] b, input logic r);
    exp_t         e;
    logic [W-1:0] g;
    in_valid  = v;
    in_bin    = b;
    out_ready = r;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_gray",  32'(out_gray),  32'(hold_g));
      chk("hold_adj",   32'(out_adj),   32'(hold_a));
    end
    hold_pend = out_valid & ~out_ready;
    hold_g    = out_gray;
    hold_a    = out_adj;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_out: observed output %0d, expected no output", out_gray);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_gray", 32'(out_gray), 32'(e.g));
        chk("out_adj",  32'(out_adj),  32'(e.a));
        n_out++;
      end
    end
    last_acc = v & in_ready;
    if (last_acc && auto_push) begin
      g = model_gray(b);
      push_exp(g, m_seen && ($countones(g ^ m_prev) == 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned i = 0; i < bound && exp_q.size() != 0; i++) begin
      run_cycle(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] sweep_g [16];
    logic [W-1:0] rb;
    int           sent;
    int           cyc;

    sweep_g = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_gray",  32'(out_gray),  32'd0);
    chk("rst_out_adj",   32'(out_adj),   32'd0);
    rst_n = 1'b1;

    // Sweep 0..15 with out_ready high
    for (int i = 0; i < 16; i++) push_exp(sweep_g[i], i != 0);
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b1, 4'(i), 1'b1);
      chk("sweep_accept", 32'(last_acc), 32'd1);
      if (i == 0) chk("lat_after_accept", 32'(out_valid), 32'd0);
      if (i == 1) chk("lat_next_edge",    32'(out_valid), 32'd1);
    end
    drain(10);
    chk("empty_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: 5, 6, 9 with out_ready low for 5 cycles
    push_exp(4'd7, 1'b0);
    push_exp(4'd5, 1'b1);
    push_exp(4'd13, 1'b1);
    run_cycle(1'b1, 4'd5, 1'b0);
    chk("bp_acc1", 32'(last_acc), 32'd1);
    run_cycle(1'b1, 4'd6, 1'b0);
    chk("bp_acc2", 32'(last_acc), 32'd1);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 4'd9, 1'b0);
      chk("bp_blocked", 32'(last_acc), 32'd0);
      chk("bp_gray",    32'(out_gray), 32'd7);
      chk("bp_adj",     32'(out_adj),  32'd0);
    end
    run_cycle(1'b1, 4'd9, 1'b1);
    chk("bp_release_acc", 32'(last_acc), 32'd1);
    drain(10);

    // Wrap-around and repeat: 15, 0, 0
    push_exp(4'd8, 1'b0);
    push_exp(4'd0, 1'b1);
    push_exp(4'd0, 1'b0);
    run_cycle(1'b1, 4'd15, 1'b1);
    run_cycle(1'b1, 4'd0, 1'b1);
    run_cycle(1'b1, 4'd0, 1'b1);
    drain(10);

    // Random stalls, 1000 words
    auto_push = 1'b1;
    sent = 0;
    cyc  = 0;
    rb   = 4'($urandom);
    while (sent < 1000 && cyc < 20000) begin
      run_cycle(1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)));
      if (last_acc) begin
        sent++;
        rb = 4'($urandom);
      end
      cyc++;
    end
    auto_push = 1'b0;
    chk("rand_sent", 32'(sent), 32'd1000);
    drain(20);
    chk("out_count", 32'(n_out), 32'd1022);

    // Mid-stream reset with two words in flight
    run_cycle(1'b1, 4'd3, 1'b0);
    run_cycle(1'b1, 4'd4, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_gray",  32'(out_gray),  32'd0);
    chk("mid_rst_out_adj",   32'(out_adj),   32'd0);
    exp_q.delete();
    m_prev    = '0;
    m_seen    = 1'b0;
    hold_pend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    push_exp(4'd5, 1'b0);
    push_exp(4'd4, 1'b1);
    run_cycle(1'b1, 4'd6, 1'b1);
    run_cycle(1'b1, 4'd7, 1'b1);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
